// File: rtl/word_red_sched.sv
// Round-robin scheduler sharing one pipelined Montgomery word reducer between NREQ requesters.
// Result lands RU_LAT+1 edges after grant; one job per requester in flight, held until rsp_ready.
module word_red_sched #(
  parameter int K      = 128,
  parameter int Q_LEN  = 64,
  parameter int TL_LEN = 26,
  parameter int NREQ   = 4,
  parameter int RU_LAT = 7,
  localparam int R  = Q_LEN - TL_LEN,
  localparam int TW = K - R,
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*K-1:0]      req_c,
  input  logic [NREQ*TL_LEN-1:0] req_qh,
  output logic [K-1:0]           ru_c,
  output logic [TL_LEN-1:0]      ru_qh,
  input  logic [TW-1:0]          ru_t,
  output logic [NREQ-1:0]        rsp_valid,
  input  logic [NREQ-1:0]        rsp_ready,
  output logic [NREQ*TW-1:0]     rsp_t,
  output logic [NREQ-1:0]        busy
);

  typedef struct packed {
    logic          vld;
    logic [IW-1:0] id;
  } tag_t;

  // Stage 0 travels alongside ru_c/ru_qh; stage RU_LAT lines up with ru_t.
  tag_t tag_q [RU_LAT+1];

  logic [IW-1:0]   ptr;
  logic [IW-1:0]   ptr_nxt;
  logic [IW-1:0]   gnt_id;
  logic [IW-1:0]   scan_id;
  logic            gnt_any;
  logic [NREQ-1:0] elig;
  logic [NREQ-1:0] grant;
  logic [NREQ-1:0] rsp_fire;

  assign elig     = req_valid & ~busy;
  assign rsp_fire = rsp_valid & rsp_ready;

  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = '0;
    grant   = '0;
    scan_id = '0;
    for (int n = 0; n < NREQ; n++) begin
      scan_id = IW'((int'(ptr) + n) % NREQ);
      if (!gnt_any && elig[scan_id]) begin
        gnt_any = 1'b1;
        gnt_id  = scan_id;
      end
    end
    if (gnt_any) grant[gnt_id] = 1'b1;
  end

  assign ptr_nxt   = (gnt_id == IW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
  // No handshake can be offered while the tag pipeline is held in reset.
  assign req_ready = rst ? grant : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr       <= '0;
      ru_c      <= '0;
      ru_qh     <= '0;
      busy      <= '0;
      rsp_valid <= '0;
      rsp_t     <= '0;
      for (int s = 0; s <= RU_LAT; s++) tag_q[s] <= '0;
    end else begin
      tag_q[0].vld <= gnt_any;
      tag_q[0].id  <= gnt_id;
      for (int s = 1; s <= RU_LAT; s++) tag_q[s] <= tag_q[s-1];

      if (gnt_any) begin
        ptr   <= ptr_nxt;
        ru_c  <= req_c[gnt_id*K +: K];
        ru_qh <= req_qh[gnt_id*TL_LEN +: TL_LEN];
      end else begin
        ru_c  <= '0;
        ru_qh <= '0;
      end

      busy <= (busy | grant) & ~rsp_fire;

      // The credit rule guarantees slot j is empty whenever its tag arrives.
      for (int j = 0; j < NREQ; j++) begin
        if (tag_q[RU_LAT].vld && tag_q[RU_LAT].id == IW'(j)) begin
          rsp_valid[j]          <= 1'b1;
          rsp_t[j*TW +: TW]     <= ru_t;
        end else if (rsp_fire[j]) begin
          rsp_valid[j]          <= 1'b0;
        end
      end
    end
  end

endmodule
